// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the processor core and its instruction feeder:
// instruction and byte widths, instruction field positions, the register-write
// opcode, and the two states of the byte-to-instruction assembler.
// No ports (package only).
// -----------------------------------------------------------------------------
package proc_pkg;

  localparam int INST_W = 16;
  localparam int BYTE_W = 8;

  // Instruction field positions (lsb/msb of each field)
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 2;
  localparam int FUNC_LSB   = 3;
  localparam int FUNC_MSB   = 6;
  localparam int RS2_LSB    = 7;
  localparam int RS2_MSB    = 9;
  localparam int RS1_LSB    = 10;
  localparam int RS1_MSB    = 12;
  localparam int RD_LSB     = 13;
  localparam int RD_MSB     = 15;

  localparam logic [2:0] OP_REGWRITE = 3'b011;

  // Assembler states: waiting for the low byte, or holding it and waiting
  // for the high byte.
  localparam logic [0:0] ASM_LOW  = 1'b0;
  localparam logic [0:0] ASM_HIGH = 1'b1;

  // Extract the opcode field of an instruction word.
  function automatic logic [2:0] instOpcode(input logic [INST_W-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Parameterized first-word-fall-through queue. The head entry is always
// presented combinationally on data_o; a pop advances to the next entry in
// the same edge. Flush empties the queue and rewinds both pointers.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   flush_i         synchronous flush, wins over push and pop
//   push_i, data_i  write data_i when not full
//   pop_i           drop the head entry when not empty
//   data_o          head entry (stale when empty)
//   level_o         number of stored entries (0..DEPTH)
//   full_o, empty_o level == DEPTH / level == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pushEn;
  logic             popEn;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rdPtr_q];

  // Requests are gated here so a pop on an empty queue or a push on a full
  // one leaves pointers and level untouched.
  assign pushEn = push_i && !full_o;
  assign popEn  = pop_i && !empty_o;

  // Next pointer and level. Pointers wrap naturally because DEPTH is a power
  // of two; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + 1'b1;
      if (popEn)  rdPtr_d = rdPtr_q + 1'b1;
      case ({pushEn, popEn})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero straight out of
  // reset; flush only rewinds pointers and leaves contents stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i && pushEn) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Assembles 16-bit instructions from a byte stream (low byte first), queues
// them in a FWFT FIFO and presents them to the core on a valid/ready pair.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   flush          synchronous flush of the queue and any held low byte
//   byte_in        incoming instruction byte
//   byte_valid     byte_in is valid
//   byte_ready     byte accepted on byte_valid && byte_ready
//   inst_out       head instruction, bits [7:0] are the low byte
//   inst_valid     queue not empty
//   inst_ready     core consumes the head on inst_valid && inst_ready
//   level          number of queued instructions
//   half_pending   a low byte is held and the high byte is awaited
// -----------------------------------------------------------------------------
module instr_fetch_queue
  import proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [INST_W-1:0]      inst_out,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   half_pending
);

  logic [0:0]        state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              byteFire;
  logic              fifoPush;

  // In HIGH the byte can only be taken if the queue has room; this looks at
  // the registered fullness only, so a same-cycle pop never frees a slot for
  // the push and there is no path from inst_ready to byte_ready.
  assign byte_ready   = (state_q == ASM_LOW) || !fifoFull;
  assign half_pending = (state_q == ASM_HIGH);
  assign inst_valid   = !fifoEmpty;

  assign byteFire = byte_valid && byte_ready && !flush;
  assign fifoPush = byteFire && (state_q == ASM_HIGH);

  // Assembler next state: each accepted byte toggles between LOW and HIGH;
  // flush drops any held low byte and returns to LOW.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = ASM_LOW;
      hold_d  = '0;
    end else if (byteFire) begin
      if (state_q == ASM_LOW) begin
        hold_d  = byte_in;
        state_d = ASM_HIGH;
      end else begin
        state_d = ASM_LOW;
      end
    end
  end

  // Assembler state and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ASM_LOW;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (fifoPush),
    .pop_i   (inst_ready),
    .data_i  ({byte_in, hold_q}),
    .data_o  (inst_out),
    .level_o (level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench for instr_fetch_queue with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  level;
  logic        half_pending;

  int compareCount;
  int mismatchCount;

  logic        streamOn;
  int          streamIdx;
  logic [15:0] streamExp [6];

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .inst_out     (inst_out),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .level        (level),
    .half_pending (half_pending)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one byte from the next falling edge and hold it until accepted,
  // with a bounded wait on byte_ready.
  task automatic applyStimulus(input logic [7:0] b);
    bit done;
    done = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("byteAcceptTimeout", {31'd0, done}, 32'd1);
    #1 byte_valid = 1'b0;
  endtask

  // Pop the head at the next edge, checking it beforehand.
  task automatic popAndCheck(input string tag, input logic [15:0] expInst);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    checkOutput(tag, {16'd0, inst_out}, {16'd0, expInst});
    inst_ready = 1'b1;
    @(posedge clk);
    #1 inst_ready = 1'b0;
  endtask

  // Streaming monitor: every head seen while the core is ready must be the
  // next expected instruction, and the queue never holds more than one.
  always @(negedge clk) begin
    if (streamOn) begin
      checkOutput("streamLevelLe1", {31'd0, (level <= 3'd1)}, 32'd1);
      if (inst_valid && inst_ready) begin
        if (streamIdx < 6)
          checkOutput("streamInst", {16'd0, inst_out}, {16'd0, streamExp[streamIdx]});
        else
          checkOutput("streamExtraInst", 32'd1, 32'd0);
        streamIdx++;
      end
    end
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    streamOn      = 1'b0;
    streamIdx     = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    byte_in       = 8'h00;
    byte_valid    = 1'b0;
    inst_ready    = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rstInstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rstLevel", {29'd0, level}, 32'd0);
    checkOutput("rstByteReady", {31'd0, byte_ready}, 32'd1);
    checkOutput("rstHalfPending", {31'd0, half_pending}, 32'd0);
    checkOutput("rstInstOut", {16'd0, inst_out}, 32'h0000);
    rst = 1'b0;

    // One instruction from two bytes
    applyStimulus(8'h33);
    @(negedge clk);
    checkOutput("halfAfterLow", {31'd0, half_pending}, 32'd1);
    checkOutput("noValidAfterLow", {31'd0, inst_valid}, 32'd0);
    applyStimulus(8'hA4);
    @(negedge clk);
    checkOutput("firstInst", {16'd0, inst_out}, 32'hA433);
    checkOutput("firstValid", {31'd0, inst_valid}, 32'd1);
    checkOutput("firstLevel", {29'd0, level}, 32'd1);
    checkOutput("firstHalf", {31'd0, half_pending}, 32'd0);
    popAndCheck("firstPop", 16'hA433);
    @(negedge clk);
    checkOutput("emptyAfterPop", {29'd0, level}, 32'd0);

    // Fill to full; pointers start at 1 so the queue wraps
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(8'(i));
      applyStimulus(8'h00);
    end
    @(negedge clk);
    checkOutput("fullLevel", {29'd0, level}, 32'd4);
    checkOutput("fullReadyLow", {31'd0, byte_ready}, 32'd1);
    applyStimulus(8'h05);
    @(negedge clk);
    checkOutput("fullReadyHigh", {31'd0, byte_ready}, 32'd0);
    checkOutput("fullHalf", {31'd0, half_pending}, 32'd1);
    popAndCheck("wrapPop1", 16'h0001);
    @(negedge clk);
    checkOutput("readyAfterPop", {31'd0, byte_ready}, 32'd1);
    checkOutput("levelAfterPop", {29'd0, level}, 32'd3);
    applyStimulus(8'h00);
    @(negedge clk);
    checkOutput("refillLevel", {29'd0, level}, 32'd4);
    // Back-to-back drain, one per cycle
    @(negedge clk);
    inst_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checkOutput("drainValid", {31'd0, inst_valid}, 32'd1);
      checkOutput("drainInst", {16'd0, inst_out}, 32'(i));
      @(negedge clk);
    end
    inst_ready = 1'b0;
    checkOutput("drainEmpty", {29'd0, level}, 32'd0);
    checkOutput("drainNoValid", {31'd0, inst_valid}, 32'd0);

    // Streaming with the core always ready
    for (int i = 0; i < 6; i++) streamExp[i] = {8'(8'hC0 + i), 8'(8'h10 + i)};
    @(negedge clk);
    inst_ready = 1'b1;
    streamOn   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'(8'h10 + i));
      applyStimulus(8'(8'hC0 + i));
    end
    repeat (3) @(negedge clk);
    streamOn   = 1'b0;
    inst_ready = 1'b0;
    checkOutput("streamCount", 32'(streamIdx), 32'd6);
    checkOutput("streamEndLevel", {29'd0, level}, 32'd0);

    // Flush with a held low byte and a byte offered in the same cycle
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    applyStimulus(8'h55);
    @(negedge clk);
    checkOutput("preFlushLevel", {29'd0, level}, 32'd1);
    checkOutput("preFlushHalf", {31'd0, half_pending}, 32'd1);
    flush      = 1'b1;
    byte_in    = 8'h66;
    byte_valid = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    byte_valid = 1'b0;
    inst_ready = 1'b0;
    @(negedge clk);
    checkOutput("flushHalf", {31'd0, half_pending}, 32'd0);
    checkOutput("flushLevel", {29'd0, level}, 32'd0);
    checkOutput("flushValid", {31'd0, inst_valid}, 32'd0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    checkOutput("postFlushInst", {16'd0, inst_out}, 32'h2211);
    checkOutput("postFlushLevel", {29'd0, level}, 32'd1);

    // Asynchronous reset mid-cycle with a partial word pending
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h77);
    @(negedge clk);
    checkOutput("preRstLevel", {29'd0, level}, 32'd2);
    checkOutput("preRstHalf", {31'd0, half_pending}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("asyncRstLevel", {29'd0, level}, 32'd0);
    checkOutput("asyncRstHalf", {31'd0, half_pending}, 32'd0);
    checkOutput("asyncRstReady", {31'd0, byte_ready}, 32'd1);
    checkOutput("asyncRstInst", {16'd0, inst_out}, 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    @(negedge clk);
    checkOutput("postRstInst", {16'd0, inst_out}, 32'h0201);
    checkOutput("postRstLevel", {29'd0, level}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
